// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronizes and debounces two raw sensor lines, then turns
// rising edges into single-cycle credit/reject pulses with holdoff and jam handling.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 2,
  parameter int JAM_CYCLES      = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_half_raw,
  input  logic coin_one_raw,
  input  logic enable,
  output logic half,
  output logic one,
  output logic reject,
  output logic jam
);

  typedef enum logic [1:0] {IDLE, HOLDOFF, JAM} state_t;

  logic [1:0] raw;
  logic [1:0] filt_lvl;
  logic [1:0] rise;
  logic [1:0] jam_hit;

  assign raw = {coin_one_raw, coin_half_raw};

  // Channel 0 is the 0.5-unit slot, channel 1 the 1-unit slot.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
      logic        sync1_reg;
      logic        sync2_reg;
      logic        filt_reg;
      logic        prev_reg;
      logic        rise_reg;
      logic [7:0]  deb_cnt_reg;
      logic [15:0] jam_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          filt_reg    <= 1'b0;
          prev_reg    <= 1'b0;
          rise_reg    <= 1'b0;
          deb_cnt_reg <= '0;
          jam_cnt_reg <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != filt_reg) begin
            if (deb_cnt_reg == 8'(DEBOUNCE_CYCLES - 1)) begin
              filt_reg    <= ~filt_reg;
              deb_cnt_reg <= '0;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + 8'd1;
            end
          end else begin
            deb_cnt_reg <= '0;
          end
          prev_reg <= filt_reg;
          rise_reg <= filt_reg & ~prev_reg;
          if (!filt_reg) begin
            jam_cnt_reg <= '0;
          end else if (jam_cnt_reg != 16'hFFFF) begin
            jam_cnt_reg <= jam_cnt_reg + 16'd1;
          end
        end
      end

      assign filt_lvl[gi] = filt_reg;
      assign rise[gi]     = rise_reg;
      assign jam_hit[gi]  = (jam_cnt_reg >= 16'(JAM_CYCLES));
    end
  endgenerate

  state_t     state_reg, state_next;
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic       half_reg, half_next;
  logic       one_reg, one_next;
  logic       reject_reg, reject_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      half_reg     <= 1'b0;
      one_reg      <= 1'b0;
      reject_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      half_reg     <= half_next;
      one_reg      <= one_next;
      reject_reg   <= reject_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    half_next     = 1'b0;
    one_next      = 1'b0;
    reject_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|jam_hit) begin
          state_next = JAM;
        end else if (|rise) begin
          state_next    = HOLDOFF;
          hold_cnt_next = '0;
          if (rise == 2'b11 || !enable) begin
            reject_next = 1'b1;
          end else if (rise[0]) begin
            half_next = 1'b1;
          end else begin
            one_next = 1'b1;
          end
        end
      end
      HOLDOFF: begin
        if (|jam_hit) begin
          state_next = JAM;
        end else begin
          // Late coins are returned, but they do not extend the holdoff window.
          reject_next = |rise;
          if (hold_cnt_reg == 8'(HOLDOFF_CYCLES - 1)) begin
            state_next = IDLE;
          end else begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
          end
        end
      end
      JAM: begin
        if (filt_lvl == 2'b00) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign half   = half_reg;
  assign one    = one_reg;
  assign reject = reject_reg;
  assign jam    = (state_reg == JAM);

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: each scenario pushes the pulses it expects
// (kind and cycle); a negedge monitor pops and compares every pulse the DUT makes.
module tb_coin_acceptor;

  localparam int K_HALF = 0;
  localparam int K_ONE  = 1;
  localparam int K_REJ  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coin_half_raw = 1'b0;
  logic coin_one_raw  = 1'b0;
  logic enable = 1'b1;
  logic half, one, reject, jam;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES(2),
    .JAM_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin_half_raw(coin_half_raw),
    .coin_one_raw(coin_one_raw),
    .enable(enable),
    .half(half),
    .one(one),
    .reject(reject),
    .jam(jam)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void push_exp(input int kind, input int at_cyc);
    exp_t e;
    e.kind = kind;
    e.cyc  = at_cyc;
    exp_q.push_back(e);
  endfunction

  // Monitor: every pulse cycle must match the oldest expected pulse.
  always @(negedge clk) begin
    int   obs_kind;
    int   n_hi;
    exp_t e;
    if (half || one || reject) begin
      obs_kind = half ? K_HALF : (one ? K_ONE : K_REJ);
      n_hi = int'(half) + int'(one) + int'(reject);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cycle %0d got kind %0d (h%0b o%0b r%0b), required no pulse",
                 cyc, obs_kind, half, one, reject);
      end else begin
        e = exp_q.pop_front();
        if (obs_kind !== e.kind || cyc !== e.cyc || n_hi !== 1) begin
          n_fail++;
          $display("FAIL pulse: got kind %0d at cycle %0d (%0d lines high), required kind %0d at cycle %0d",
                   obs_kind, cyc, n_hi, e.kind, e.cyc);
        end else begin
          $display("pulse ok: kind %0d at cycle %0d", obs_kind, cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_cmp++;
    if ({half, one, reject, jam} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got h%0b o%0b r%0b j%0b, required all 0", half, one, reject, jam);
    end
    rst = 1'b0;
    tick(3);
    n_cmp++;
    if ({half, one, reject, jam} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got h%0b o%0b r%0b j%0b, required all 0", half, one, reject, jam);
    end
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected pulses never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      $display("%s done at cycle %0d", name, cyc);
    end
  endtask

  task automatic test_clean_half;
    int t;
    t = cyc;
    coin_half_raw = 1'b1;
    push_exp(K_HALF, t + 8);
    tick(10);
    coin_half_raw = 1'b0;
    tick(25);
    check_drained("test_clean_half");
  endtask

  task automatic test_bounce;
    int t;
    for (int i = 0; i < 4; i++) begin
      coin_one_raw = (i % 2 == 0);
      tick(1);
    end
    t = cyc;
    coin_one_raw = 1'b1;
    push_exp(K_ONE, t + 8);
    tick(10);
    coin_one_raw = 1'b0;
    tick(25);
    // A 3-sample glitch must never reach the filtered level.
    coin_one_raw = 1'b1;
    tick(3);
    coin_one_raw = 1'b0;
    tick(25);
    check_drained("test_bounce");
  endtask

  task automatic test_simultaneous_holdoff;
    int t;
    t = cyc;
    coin_half_raw = 1'b1;
    coin_one_raw  = 1'b1;
    push_exp(K_REJ, t + 8);
    tick(10);
    coin_half_raw = 1'b0;
    coin_one_raw  = 1'b0;
    tick(30);
    // 1-unit event lands in the second holdoff cycle after a half credit.
    t = cyc;
    coin_half_raw = 1'b1;
    push_exp(K_HALF, t + 8);
    push_exp(K_REJ, t + 10);
    tick(2);
    coin_one_raw = 1'b1;
    tick(8);
    coin_half_raw = 1'b0;
    tick(2);
    coin_one_raw = 1'b0;
    tick(30);
    // One cycle later the holdoff has expired and the coin is credited.
    t = cyc;
    coin_half_raw = 1'b1;
    push_exp(K_HALF, t + 8);
    push_exp(K_ONE, t + 11);
    tick(3);
    coin_one_raw = 1'b1;
    tick(7);
    coin_half_raw = 1'b0;
    tick(3);
    coin_one_raw = 1'b0;
    tick(30);
    check_drained("test_simultaneous_holdoff");
  endtask

  task automatic test_disabled;
    int t;
    enable = 1'b0;
    t = cyc;
    coin_one_raw = 1'b1;
    push_exp(K_REJ, t + 8);
    tick(10);
    coin_one_raw = 1'b0;
    tick(25);
    enable = 1'b1;
    check_drained("test_disabled");
  endtask

  task automatic test_jam;
    int t;
    int r;
    t = cyc;
    coin_half_raw = 1'b1;
    push_exp(K_HALF, t + 8);
    wait_cyc(t + 70);
    n_cmp++;
    if (jam !== 1'b0) begin
      n_fail++;
      $display("FAIL jam_early: got %0b at cycle %0d, required 0", jam, cyc);
    end
    wait_cyc(t + 71);
    n_cmp++;
    if (jam !== 1'b1) begin
      n_fail++;
      $display("FAIL jam_set: got %0b at cycle %0d, required 1", jam, cyc);
    end
    wait_cyc(t + 100);
    r = cyc;
    coin_half_raw = 1'b0;
    wait_cyc(r + 6);
    n_cmp++;
    if (jam !== 1'b1) begin
      n_fail++;
      $display("FAIL jam_hold: got %0b at cycle %0d, required 1", jam, cyc);
    end
    wait_cyc(r + 7);
    n_cmp++;
    if (jam !== 1'b0) begin
      n_fail++;
      $display("FAIL jam_clear: got %0b at cycle %0d, required 0", jam, cyc);
    end
    tick(20);
    t = cyc;
    coin_one_raw = 1'b1;
    push_exp(K_ONE, t + 8);
    tick(10);
    coin_one_raw = 1'b0;
    tick(25);
    check_drained("test_jam");
  endtask

  task automatic test_reset_mid;
    int t;
    t = cyc;
    coin_half_raw = 1'b1;
    wait_cyc(t + 7);
    rst = 1'b1;
    coin_half_raw = 1'b0;
    wait_cyc(t + 8);
    n_cmp++;
    if ({half, one, reject, jam} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: got h%0b o%0b r%0b j%0b, required all 0", half, one, reject, jam);
    end
    rst = 1'b0;
    wait_cyc(t + 9);
    n_cmp++;
    if ({half, one, reject, jam} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_after: got h%0b o%0b r%0b j%0b, required all 0", half, one, reject, jam);
    end
    tick(25);
    check_drained("test_reset_mid");
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_clean_half;
    test_bounce;
    test_simultaneous_holdoff;
    test_disabled;
    test_jam;
    test_reset_mid;
    test_clean_half;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
